// File: rtl/adc_seg_pkg.sv
// Shared constants for the ADC-to-7-segment sampler: nibble width, BCD limit
// and update-mode encodings.
package adc_seg_pkg;

  localparam int         NIB_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic MODE_PERIODIC  = 1'b0;
  localparam logic MODE_IMMEDIATE = 1'b1;

  function automatic logic is_bcd(input logic [NIB_W-1:0] value);
    return (value <= BCD_MAX);
  endfunction

endpackage

// File: rtl/adc_nib_rx.sv
// Serial ADC nibble receiver: one bit per rising edge of the data-ready flag,
// MSB first, with idle-timeout realignment and a BCD validity check.
module adc_nib_rx
  import adc_seg_pkg::*;
#(
  parameter int IDLE_TO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ad_bit,
  input  logic             flag,
  output logic [NIB_W-1:0] nib,
  output logic             nib_ok,
  output logic             nib_bad
);

  localparam int           IW        = $clog2(IDLE_TO);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TO - 1);

  logic             flag_d;
  logic             bit_stb;
  logic [NIB_W-1:0] nib_sr;
  logic [1:0]       bit_idx;
  logic             nib_done;
  logic [IW-1:0]    idle_cnt;

  // A strobe arriving in the timeout cycle wins over the realignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_d   <= 1'b0;
      bit_stb  <= 1'b0;
      nib_sr   <= '0;
      bit_idx  <= 2'd0;
      nib_done <= 1'b0;
      idle_cnt <= '0;
    end else begin
      flag_d   <= flag;
      bit_stb  <= flag & ~flag_d;
      nib_done <= 1'b0;
      if (bit_stb) begin
        nib_sr   <= {nib_sr[NIB_W-2:0], ad_bit};
        bit_idx  <= bit_idx + 2'd1;
        nib_done <= (bit_idx == 2'd3);
        idle_cnt <= '0;
      end else begin
        if (idle_cnt != IDLE_LAST) begin
          idle_cnt <= idle_cnt + IW'(1);
        end
        if ((idle_cnt == IDLE_LAST) && (bit_idx != 2'd0)) begin
          bit_idx <= 2'd0;
          nib_sr  <= '0;
        end
      end
    end
  end

  assign nib     = nib_sr;
  assign nib_ok  = nib_done &  is_bcd(nib_sr);
  assign nib_bad = nib_done & ~is_bcd(nib_sr);

endmodule

// File: rtl/adc_bcd_sampler.sv
// ADC-to-display sampler: paces ADC conversions, collects BCD digits into a
// display shift register and publishes it periodically or per accepted digit.
module adc_bcd_sampler
  import adc_seg_pkg::*;
#(
  parameter int PERIOD_CYC = 2000000,
  parameter int CONV_DIV   = 32,
  parameter int DIGITS     = 3,
  parameter int IDLE_TO    = 64,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ad_bit,
  input  logic                  flag,
  input  logic                  hold,
  input  logic                  mode,
  output logic                  convert,
  output logic [4*DIGITS-1:0]   num,
  output logic                  num_valid,
  output logic                  tick,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam int            PW     = $clog2(PERIOD_CYC);
  localparam int            CW     = $clog2(CONV_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CONV_DIV - 1);

  logic [PW-1:0]       p_cnt;
  logic [CW-1:0]       c_cnt;
  logic [NIB_W-1:0]    nib;
  logic                nib_ok;
  logic                nib_bad;
  logic [4*DIGITS-1:0] disp_sr;
  logic [4*DIGITS-1:0] disp_shift;
  logic                acc_stb;
  logic                load;

  adc_nib_rx #(
    .IDLE_TO (IDLE_TO)
  ) u_nib_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ad_bit  (ad_bit),
    .flag    (flag),
    .nib     (nib),
    .nib_ok  (nib_ok),
    .nib_bad (nib_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_cnt <= '0;
      c_cnt <= '0;
    end else begin
      p_cnt <= (p_cnt == P_LAST) ? '0 : p_cnt + PW'(1);
      c_cnt <= (c_cnt == C_LAST) ? '0 : c_cnt + CW'(1);
    end
  end

  assign tick    = (p_cnt == P_LAST);
  assign convert = (c_cnt == C_LAST);

  generate
    if (DIGITS == 1) begin : g_one_digit
      assign disp_shift = nib;
    end else begin : g_multi_digit
      assign disp_shift = {disp_sr[4*DIGITS-5:0], nib};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_sr <= '0;
      acc_stb <= 1'b0;
      err_cnt <= '0;
    end else begin
      acc_stb <= nib_ok;
      if (nib_ok) begin
        disp_sr <= disp_shift;
      end
      if (nib_bad && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

  // A tick coinciding with an accepted digit still produces a single load.
  assign load = tick | ((mode == MODE_IMMEDIATE) & acc_stb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num       <= '0;
      num_valid <= 1'b0;
    end else if (hold) begin
      num_valid <= 1'b0;
    end else if (load) begin
      num       <= disp_sr;
      num_valid <= 1'b1;
    end else begin
      num_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_bcd_sampler.sv
// Self-checking bench for adc_bcd_sampler: cycle model for convert/tick plus a
// scoreboard of expected display loads.
module tb_adc_bcd_sampler;

  localparam int PERIOD_CYC = 100;
  localparam int CONV_DIV   = 8;
  localparam int IDLE_TO    = 20;
  localparam int DIGITS     = 3;
  localparam int ERR_W      = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ad_bit = 1'b0;
  logic             flag = 1'b0;
  logic             hold = 1'b0;
  logic             mode = 1'b0;
  logic             convert;
  logic [11:0]      num;
  logic             num_valid;
  logic             tick;
  logic [ERR_W-1:0] err_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          mcyc = 0;
  logic [11:0] model_disp = 12'h000;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [3:0] nib;
    logic       mode;
    int         err;
  } vec_t;

  vec_t vecs[9];

  adc_bcd_sampler #(
    .PERIOD_CYC (PERIOD_CYC),
    .CONV_DIV   (CONV_DIV),
    .DIGITS     (DIGITS),
    .IDLE_TO    (IDLE_TO),
    .ERR_W      (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ad_bit    (ad_bit),
    .flag      (flag),
    .hold      (hold),
    .mode      (mode),
    .convert   (convert),
    .num       (num),
    .num_valid (num_valid),
    .tick      (tick),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcyc <= 0;
    else        mcyc <= mcyc + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Cycle model for the pacing outputs and scoreboard for display loads.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("convert", convert, (mcyc % CONV_DIV) == CONV_DIV - 1);
      checkOutput("tick", tick, (mcyc % PERIOD_CYC) == PERIOD_CYC - 1);
      if (((mcyc % PERIOD_CYC) == PERIOD_CYC - 1) && !hold) exp_q.push_back(model_disp);
      if (num_valid) begin
        checkOutput("num_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) checkOutput("num_load", num, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendBit(input logic b);
    @(posedge clk); #1;
    ad_bit = b;
    flag   = 1'b1;
    @(posedge clk); #1;
    flag   = 1'b0;
  endtask

  task automatic sendNibble(input logic [3:0] n);
    for (int i = 3; i >= 0; i--) sendBit(n[i]);
  endtask

  task automatic acceptDigit(input logic [3:0] n);
    model_disp = {model_disp[7:0], n};
    if (mode && !hold) exp_q.push_back(model_disp);
  endtask

  // Keep nibble completion clear of the tick edge so loads never collide.
  task automatic waitSafe(input int span);
    int ph;
    for (int k = 0; k < 2 * PERIOD_CYC; k++) begin
      ph = mcyc % PERIOD_CYC;
      if (ph >= 2 && ph + span <= PERIOD_CYC - 5) break;
      @(negedge clk);
    end
  endtask

  task automatic waitPhase(input int p, input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 3 * PERIOD_CYC; k++) begin
      @(negedge clk);
      if ((mcyc % PERIOD_CYC) == p) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput(name, found, 1);
  endtask

  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    @(posedge clk); #1;
    mode = v.mode;
    waitSafe(16);
    sendNibble(v.nib);
    if (v.nib <= 4'd9) acceptDigit(v.nib);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("err_cnt_row%0d", idx), err_cnt, v.err);
  endtask

  initial begin
    logic seen_tick;

    vecs[0] = '{4'h1, 1'b0, 0};
    vecs[1] = '{4'h2, 1'b0, 0};
    vecs[2] = '{4'h3, 1'b0, 0};
    vecs[3] = '{4'hA, 1'b0, 1};
    vecs[4] = '{4'h4, 1'b0, 1};
    vecs[5] = '{4'hF, 1'b1, 2};
    vecs[6] = '{4'hB, 1'b1, 3};
    vecs[7] = '{4'hC, 1'b1, 3};
    vecs[8] = '{4'hD, 1'b1, 3};

    repeat (3) @(negedge clk);
    checkOutput("reset_num", num, 0);
    checkOutput("reset_num_valid", num_valid, 0);
    checkOutput("reset_convert", convert, 0);
    checkOutput("reset_tick", tick, 0);
    checkOutput("reset_err", err_cnt, 0);
    #2 rst_n = 1'b1;

    for (int k = 0; k < 300 && mcyc < 210; k++) @(negedge clk);
    checkOutput("idle_num", num, 0);
    checkOutput("idle_err", err_cnt, 0);

    waitSafe(50);
    for (int i = 0; i <= 2; i++) applyStimulus(i);
    checkOutput("mode0_num_held", num, 12'h000);
    waitPhase(1, "mode0_tick_reached");
    checkOutput("mode0_num_after_tick", num, 12'h123);

    for (int i = 3; i <= 4; i++) applyStimulus(i);
    waitPhase(1, "bad_nib_tick_reached");
    checkOutput("bad_nib_num_after_tick", num, 12'h234);

    @(posedge clk); #1;
    mode = 1'b1;
    waitSafe(16);
    sendNibble(4'h7);
    acceptDigit(4'h7);
    repeat (3) @(negedge clk);
    checkOutput("latency_num_before", num, 12'h234);
    checkOutput("latency_valid_before", num_valid, 0);
    @(negedge clk);
    checkOutput("latency_num_at_e3", num, 12'h347);
    checkOutput("latency_valid_at_e3", num_valid, 1);

    for (int i = 5; i <= 8; i++) applyStimulus(i);

    waitSafe(50);
    sendBit(1'b1);
    sendBit(1'b1);
    repeat (25) @(posedge clk);
    sendNibble(4'h5);
    acceptDigit(4'h5);
    repeat (4) @(negedge clk);
    checkOutput("realign_num", num, 12'h475);
    checkOutput("realign_err", err_cnt, 3);

    @(posedge clk); #1;
    hold = 1'b1;
    sendNibble(4'h6);
    acceptDigit(4'h6);
    seen_tick = 1'b0;
    for (int k = 0; k < 3 * PERIOD_CYC; k++) begin
      @(negedge clk);
      checkOutput("hold_num_frozen", num, 12'h475);
      checkOutput("hold_no_valid", num_valid, 0);
      if ((mcyc % PERIOD_CYC) == PERIOD_CYC - 1) seen_tick = 1'b1;
      if (seen_tick && (mcyc % PERIOD_CYC) == 5) break;
    end
    checkOutput("hold_spanned_tick", seen_tick, 1);
    @(posedge clk); #1;
    hold = 1'b0;
    waitPhase(1, "release_tick_reached");
    checkOutput("release_num", num, 12'h756);

    waitSafe(30);
    sendBit(1'b1);
    sendBit(1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_num", num, 0);
    checkOutput("midreset_num_valid", num_valid, 0);
    checkOutput("midreset_convert", convert, 0);
    checkOutput("midreset_tick", tick, 0);
    checkOutput("midreset_err", err_cnt, 0);
    exp_q.delete();
    model_disp = 12'h000;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    sendNibble(4'h6);
    acceptDigit(4'h6);
    repeat (5) @(negedge clk);
    checkOutput("fresh_nibble_num", num, 12'h006);
    checkOutput("fresh_nibble_err", err_cnt, 0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_bcd_sampler.md
Name: adc_bcd_sampler

Overview:
Parametrised successor to the 2-second ADC-to-display sampler. Paces the serial ADC with periodic convert pulses and deserialises one data bit per ADC data-ready edge into 4-bit BCD digits. Rejects non-BCD nibbles and counts them, shifts accepted digits into a DIGITS-wide display shift register, and publishes it to the 7-segment driver either once per period or immediately. Adds a hold (freeze) input and idle-timeout realignment of the nibble framing.

Parameters:
PERIOD_CYC, 2000000, display update period in clk cycles (>=2)
CONV_DIV, 32, convert pulse period in clk cycles (>=2)
DIGITS, 3, number of BCD digits on num (>=1)
IDLE_TO, 64, cycles without a data-ready edge before a partial nibble is discarded (>=2)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ad_bit  input  1  serial data bit from ADC
flag  input  1  ADC data-ready, level signal, synchronous to clk
hold  input  1  1 = freeze num (capture continues)
mode  input  1  0 = periodic update, 1 = immediate update per accepted digit
convert  output  1  one-cycle convert request to ADC
num  output  4*DIGITS  BCD digits to seg driver, newest digit in [3:0]
num_valid  output  1  one-cycle pulse, registered, on each num load
tick  output  1  one-cycle period marker
err_cnt  output  ERR_W  saturating count of rejected nibbles

Behaviour:
- Reset (async, rst_n=0): all counters, shift registers, num, err_cnt cleared to 0; num_valid=0; partial nibble discarded.
- Period counter p_cnt 0..PERIOD_CYC-1, wraps. tick = (p_cnt==PERIOD_CYC-1), decoded from register.
- Convert counter c_cnt 0..CONV_DIV-1, wraps. convert = (c_cnt==CONV_DIV-1). First pulse at cycle CONV_DIV-1 after reset release.
- Edge detect: flag_d <= flag. bit_stb <= flag & ~flag_d (registered).
- On bit_stb: nib_sr <= {nib_sr[2:0], ad_bit} (MSB first); bit_idx <= bit_idx+1 mod 4; nib_done <= (bit_idx==3).
- On nib_done:
  - nib_sr<=9: disp_sr <= {disp_sr[4*DIGITS-5:0], nib_sr}; acc_stb<=1. For DIGITS=1, disp_sr <= nib_sr.
  - nib_sr>9: disp_sr unchanged; err_cnt += 1, saturating at all-ones.
- num load, when hold=0:
  - mode=0: on tick.
  - mode=1: on acc_stb or tick.
  - Load action: num <= disp_sr; num_valid <= 1 on the same edge.
  - Tick and acc_stb together: one load, one num_valid pulse.
- hold=1: num frozen, num_valid=0, no pending load retained. Deserialiser, disp_sr and err_cnt keep running.
- Latency: flag rising edge sampled at edge E0 -> bit shift at E1 -> disp_sr at E2 (4th bit) -> num/num_valid at E3 (mode=1).
- Idle realign: idle_cnt clears on bit_stb, otherwise increments, saturating at IDLE_TO-1. At idle_cnt==IDLE_TO-1 with bit_idx!=0: bit_idx<=0, nib_sr<=0, err_cnt unchanged. A bit_stb in the same cycle wins: the bit is shifted and idle_cnt cleared.
- mode and hold are sampled every cycle; changing them mid-nibble does not disturb framing.

Decomposition:
- Package adc_seg_pkg:
  - NIB_W=4, BCD_MAX=4'd9
  - MODE_PERIODIC=1'b0, MODE_IMMEDIATE=1'b1
- Sub-module adc_nib_rx holds the edge detect, nib_sr, bit_idx, idle timeout and BCD check. Outputs: nib, nib_ok, nib_bad pulses.
- Top level holds the counters, disp_sr, num load and err_cnt.

Test Plan:
All scenarios use PERIOD_CYC=100, CONV_DIV=8, IDLE_TO=20, DIGITS=3, ERR_W=2.
1. Reset release, idle inputs -> convert high at cycles 7,15,23,...; tick at 99,199; num=0; num_valid pulses at each tick (load of 0); err_cnt=0.
2. mode=0: bits 0001,0010,0011 via flag edges -> num stays 0 until the next tick, then num=12'h123 with a single num_valid.
3. Nibble 1010 then 0100 -> err_cnt=1; disp_sr shifts in 4 only; after tick num=12'h234.
4. mode=1: nibble 0111 -> num updates exactly 3 cycles after the 4th flag rising edge is sampled; one num_valid. Four bad nibbles -> err_cnt saturates at 2'b11.
5. Bits 1,1, then 25 idle cycles, then 0101 -> realigned; digit 5 accepted, err_cnt unchanged. hold=1 across a tick -> num unchanged, no num_valid.
6. rst_n asserted mid-nibble (after 2 bits) -> all outputs 0 immediately; next 4 bits form a fresh nibble.
